// File: rtl/piezo_keyboard_tone_gen.sv
// piezo_keyboard_tone_gen: priority key-to-square-wave tone player with octave shift and 7-seg key display
// Ports:
//   clk        in   1       system clock, rising edge
//   resetn     in   1       asynchronous active-low reset
//   in         in   N_KEYS  active-high keys, asynchronous to clk (in[0] has highest priority)
//   octave     in   2       octave shift, effective half period = HALF[k] >> octave
//   piezo      out  1       square-wave tone
//   segment    out  7       {a,b,c,d,e,f,g} active-high, blank when idle
//   note_valid out  1       high while a tone is generated
// Optional feature: define PIEZO_SUSTAIN_EN to keep the last note sounding SUSTAIN_CYC clocks after release.
module piezo_keyboard_tone_gen #(
    parameter int CLK_HZ      = 1_000_000,
    parameter int N_KEYS      = 8,
    parameter int SUSTAIN_CYC = 250_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] in,
    input  logic [1:0]        octave,
    output logic              piezo,
    output logic [6:0]        segment,
    output logic              note_valid
);
    localparam int F_CHZ [8] = '{26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325};

    function automatic int half_c(input int k);
        return int'((64'(CLK_HZ) * 64'd50) / 64'(F_CHZ[k]));
    endfunction

    localparam int CW = $clog2(half_c(0) + 1);
    localparam logic [CW-1:0] HALF [8] = '{CW'(half_c(0)), CW'(half_c(1)), CW'(half_c(2)), CW'(half_c(3)),
                                           CW'(half_c(4)), CW'(half_c(5)), CW'(half_c(6)), CW'(half_c(7))};
    localparam logic [6:0] SEG [8] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                       7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111};

    if (N_KEYS < 1 || N_KEYS > 8 || SUSTAIN_CYC < 1) begin : g_bad_param
        $error("piezo_keyboard_tone_gen: N_KEYS must be 1..8 and SUSTAIN_CYC >= 1");
    end

`ifdef PIEZO_SUSTAIN_EN
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SUSTAIN} state_t;
    localparam state_t S_REL = S_SUSTAIN;
    localparam int SW = $clog2(SUSTAIN_CYC + 1);
    logic [SW-1:0] r_sus;
`else
    typedef enum logic [1:0] {S_IDLE, S_PLAY} state_t;
    localparam state_t S_REL = S_IDLE;
`endif

    logic [N_KEYS-1:0] r_sync1, r_sync2;
    logic [1:0]        r_oct;
    state_t            r_state, w_state_nxt;
    logic [2:0]        r_key, w_key, w_key_nxt;
    logic              w_any, w_restart;
    logic [CW-1:0]     r_cnt, r_half;
    logic              r_piezo;

    // Lowest-indexed active key wins.
    always_comb begin
        w_key = '0;
        for (int i = N_KEYS - 1; i >= 0; i--)
            if (r_sync2[i]) w_key = 3'(i);
        w_any = |r_sync2;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE: if (w_any) begin
                w_state_nxt = S_PLAY;
                w_key_nxt   = w_key;
                w_restart   = 1'b1;
            end
            S_PLAY: if (!w_any) begin
                w_state_nxt = S_REL;
            end else if (w_key != r_key) begin
                w_key_nxt = w_key;
                w_restart = 1'b1;
            end
`ifdef PIEZO_SUSTAIN_EN
            // Any press restarts the phase, even for the key that is sustaining.
            S_SUSTAIN: if (w_any) begin
                w_state_nxt = S_PLAY;
                w_key_nxt   = w_key;
                w_restart   = 1'b1;
            end else if (r_sus == SW'(SUSTAIN_CYC - 1)) begin
                w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        note_valid = r_state != S_IDLE;
        segment    = note_valid ? SEG[r_key] : 7'b0000000;
        piezo      = r_piezo;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_oct   <= '0;
            r_state <= S_IDLE;
            r_key   <= '0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
            r_oct   <= octave;
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
        end
    end

`ifdef PIEZO_SUSTAIN_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_sus <= '0;
        else         r_sus <= (r_state == S_SUSTAIN) ? r_sus + SW'(1) : '0;
    end
`endif

    // The half period is latched only on a restart or a wrap, so an octave change
    // never shortens the half period already in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_half  <= HALF[0];
            r_piezo <= 1'b0;
        end else if (w_state_nxt == S_IDLE) begin
            r_cnt   <= '0;
            r_piezo <= 1'b0;
        end else if (w_restart) begin
            r_cnt   <= '0;
            r_piezo <= 1'b0;
            r_half  <= HALF[w_key] >> r_oct;
        end else if (r_cnt >= r_half - CW'(1)) begin
            r_cnt   <= '0;
            r_piezo <= ~r_piezo;
            r_half  <= HALF[r_key] >> r_oct;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_piezo_keyboard_tone_gen.sv
// tb_piezo_keyboard_tone_gen: directed self-checking bench for piezo_keyboard_tone_gen (default build)
module tb_piezo_keyboard_tone_gen;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] in_keys = '0;
    logic [1:0] octave = '0;
    logic       piezo;
    logic [6:0] segment;
    logic       note_valid;
    int         n_vec = 0;
    int         n_err = 0;

    piezo_keyboard_tone_gen dut (
        .clk(clk), .resetn(resetn), .in(in_keys), .octave(octave),
        .piezo(piezo), .segment(segment), .note_valid(note_valid)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clocks until piezo changes; -1 if it never does within the bound.
    task automatic wait_toggle(output int n);
        logic p;
        int   c;
        p = piezo;
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (piezo === p && c < 4000);
        n = (piezo === p) ? -1 : c;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        in_keys = 8'hFF;
        tick(4);
        n_vec++; if (piezo !== 1'b0) begin n_err++; $display("FAIL rst_piezo got %b want 0", piezo); end
        n_vec++; if (segment !== 7'b0000000) begin n_err++; $display("FAIL rst_seg got %b want 0000000", segment); end
        n_vec++; if (note_valid !== 1'b0) begin n_err++; $display("FAIL rst_nv got %b want 0", note_valid); end
        @(negedge clk);
        in_keys = '0;
        resetn = 1'b1;
        tick(6);
        n_vec++; if (note_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_nv got %b want 0", note_valid); end
        n_vec++; if (segment !== 7'b0000000) begin n_err++; $display("FAIL post_rst_seg got %b want 0000000", segment); end
    endtask

    task automatic test_key1;
        int n;
        @(negedge clk);
        in_keys = 8'b0000_0001;
        tick(2);
        n_vec++; if (note_valid !== 1'b0) begin n_err++; $display("FAIL k1_lat2_nv got %b want 0", note_valid); end
        tick(1);
        n_vec++; if (note_valid !== 1'b1) begin n_err++; $display("FAIL k1_lat3_nv got %b want 1", note_valid); end
        n_vec++; if (segment !== 7'b0110000) begin n_err++; $display("FAIL k1_seg got %b want 0110000", segment); end
        n_vec++; if (piezo !== 1'b0) begin n_err++; $display("FAIL k1_phase0 got %b want 0", piezo); end
        wait_toggle(n);
        n_vec++; if (n !== 1911) begin n_err++; $display("FAIL k1_first_half got %0d want 1911", n); end
        wait_toggle(n);
        n_vec++; if (n !== 1911) begin n_err++; $display("FAIL k1_second_half got %0d want 1911", n); end
        @(negedge clk);
        in_keys = '0;
        tick(2);
        n_vec++; if (note_valid !== 1'b1) begin n_err++; $display("FAIL k1_rel_lat2 got %b want 1", note_valid); end
        tick(1);
        n_vec++; if (note_valid !== 1'b0) begin n_err++; $display("FAIL k1_rel_nv got %b want 0", note_valid); end
        n_vec++; if (segment !== 7'b0000000) begin n_err++; $display("FAIL k1_rel_seg got %b want 0000000", segment); end
        n_vec++; if (piezo !== 1'b0) begin n_err++; $display("FAIL k1_rel_piezo got %b want 0", piezo); end
    endtask

    task automatic test_priority;
        int n;
        @(negedge clk);
        in_keys = 8'b1000_0100;
        tick(3);
        n_vec++; if (segment !== 7'b1111001) begin n_err++; $display("FAIL pri_seg3 got %b want 1111001", segment); end
        wait_toggle(n);
        n_vec++; if (n !== 1516) begin n_err++; $display("FAIL pri_half3 got %0d want 1516", n); end
        tick(500);
        @(negedge clk);
        in_keys = 8'b1000_0000;
        tick(2);
        n_vec++; if (segment !== 7'b1111001) begin n_err++; $display("FAIL pri_seg_hold got %b want 1111001", segment); end
        n_vec++; if (piezo !== 1'b1) begin n_err++; $display("FAIL pri_piezo_hold got %b want 1", piezo); end
        tick(1);
        n_vec++; if (segment !== 7'b1111111) begin n_err++; $display("FAIL pri_seg8 got %b want 1111111", segment); end
        n_vec++; if (piezo !== 1'b0) begin n_err++; $display("FAIL pri_restart got %b want 0", piezo); end
        n_vec++; if (note_valid !== 1'b1) begin n_err++; $display("FAIL pri_nv got %b want 1", note_valid); end
        wait_toggle(n);
        n_vec++; if (n !== 955) begin n_err++; $display("FAIL pri_half8 got %0d want 955", n); end
        @(negedge clk);
        in_keys = '0;
        tick(3);
        n_vec++; if (note_valid !== 1'b0) begin n_err++; $display("FAIL pri_rel_nv got %b want 0", note_valid); end
    endtask

    task automatic test_octave;
        int n;
        @(negedge clk);
        in_keys = 8'b0010_0000;
        tick(3);
        n_vec++; if (segment !== 7'b1011111) begin n_err++; $display("FAIL oct_seg6 got %b want 1011111", segment); end
        wait_toggle(n);
        n_vec++; if (n !== 1136) begin n_err++; $display("FAIL oct_half0 got %0d want 1136", n); end
        repeat (299) @(posedge clk);
        @(negedge clk);
        octave = 2'd2;
        wait_toggle(n);
        n_vec++; if (n !== 837) begin n_err++; $display("FAIL oct_finish_old got %0d want 837", n); end
        wait_toggle(n);
        n_vec++; if (n !== 284) begin n_err++; $display("FAIL oct_half2_a got %0d want 284", n); end
        wait_toggle(n);
        n_vec++; if (n !== 284) begin n_err++; $display("FAIL oct_half2_b got %0d want 284", n); end
        @(negedge clk);
        octave = 2'd0;
        in_keys = '0;
        tick(3);
        n_vec++; if (note_valid !== 1'b0) begin n_err++; $display("FAIL oct_rel_nv got %b want 0", note_valid); end
    endtask

    task automatic test_reset_mid_note;
        int n;
        @(negedge clk);
        in_keys = 8'b0001_0000;
        tick(3);
        wait_toggle(n);
        n_vec++; if (n !== 1275) begin n_err++; $display("FAIL rmid_half5 got %0d want 1275", n); end
        tick(400);
        n_vec++; if (piezo !== 1'b1) begin n_err++; $display("FAIL rmid_pre got %b want 1", piezo); end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_vec++; if (piezo !== 1'b0) begin n_err++; $display("FAIL rmid_async_piezo got %b want 0", piezo); end
        n_vec++; if (segment !== 7'b0000000) begin n_err++; $display("FAIL rmid_async_seg got %b want 0000000", segment); end
        n_vec++; if (note_valid !== 1'b0) begin n_err++; $display("FAIL rmid_async_nv got %b want 0", note_valid); end
        @(negedge clk);
        resetn = 1'b1;
        tick(2);
        n_vec++; if (note_valid !== 1'b0) begin n_err++; $display("FAIL rmid_lat2 got %b want 0", note_valid); end
        tick(1);
        n_vec++; if (note_valid !== 1'b1) begin n_err++; $display("FAIL rmid_lat3 got %b want 1", note_valid); end
        n_vec++; if (segment !== 7'b1011011) begin n_err++; $display("FAIL rmid_seg5 got %b want 1011011", segment); end
        n_vec++; if (piezo !== 1'b0) begin n_err++; $display("FAIL rmid_phase0 got %b want 0", piezo); end
        wait_toggle(n);
        n_vec++; if (n !== 1275) begin n_err++; $display("FAIL rmid_restart_half got %0d want 1275", n); end
        @(negedge clk);
        in_keys = '0;
        tick(3);
    endtask

    task automatic test_segments;
        logic [6:0] seg_exp [8];
        logic [7:0] v;
        seg_exp = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111};
        for (int k = 0; k < 8; k++) begin
            v = 8'hFF;
            @(negedge clk);
            in_keys = v << k;
            tick(3);
            n_vec++; if (segment !== seg_exp[k]) begin n_err++; $display("FAIL seg_key%0d got %b want %b", k + 1, segment, seg_exp[k]); end
            @(negedge clk);
            in_keys = '0;
            tick(3);
            n_vec++; if (segment !== 7'b0000000) begin n_err++; $display("FAIL seg_blank%0d got %b want 0000000", k + 1, segment); end
        end
    endtask

    initial begin
        test_reset;
        test_key1;
        test_priority;
        test_octave;
        test_reset_mid_note;
        test_segments;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
